// File: rtl/game_pkg.sv
// Shared definitions for the whack-a-mole game flow: phase encodings reused by
// the top-level display/LED/RGB muxes, plus the default phase lengths.
package game_pkg;

  typedef enum logic [1:0] {
    PH_COUNTDOWN = 2'b00,
    PH_PLAY      = 2'b01,
    PH_OVER      = 2'b10,
    PH_IDLE      = 2'b11
  } phase_e;

  localparam int TIMER_W            = 6;
  localparam int DEF_COUNTDOWN_SECS = 5;
  localparam int DEF_PLAY_SECS      = 30;
  localparam int DEF_OVER_SECS      = 10;
  localparam int DEF_SCORE_W        = 16;

  // Every timed phase must fit the 6-bit second counter and last at least 1 s.
  function automatic bit secs_ok(input int secs);
    return (secs >= 1) && (secs <= (1 << TIMER_W) - 1);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter used for all timed game phases; load wins over decrement.
module phase_timer
  import game_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               dec_en,
  output logic [TIMER_W-1:0] count,
  output logic               expire
);

  logic [TIMER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec_en && (count_q != '0)) begin
      count_d = count_q - {{(TIMER_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign expire = dec_en && (count_q == {{(TIMER_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: IDLE -> COUNTDOWN -> PLAY -> GAME_OVER -> IDLE, owning
// the round timer, score, session high score and the mole-advance enable.
module game_sequencer
  import game_pkg::*;
#(
  parameter int COUNTDOWN_SECS = DEF_COUNTDOWN_SECS,
  parameter int PLAY_SECS      = DEF_PLAY_SECS,
  parameter int OVER_SECS      = DEF_OVER_SECS,
  parameter int SCORE_W        = DEF_SCORE_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick_1hz,
  input  logic               tick_2hz,
  input  logic               start,
  input  logic               hit,
  input  logic               level_select,
  output logic [1:0]         phase,
  output logic [5:0]         seconds_left,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic               new_high,
  output logic               mole_step,
  output logic               level_latched
);

  if (!secs_ok(COUNTDOWN_SECS) || !secs_ok(PLAY_SECS) || !secs_ok(OVER_SECS)) begin : g_bad_secs
    $error("game_sequencer: every *_SECS parameter must be in 1..63");
  end

  localparam logic [TIMER_W-1:0] CD_LOAD   = TIMER_W'(COUNTDOWN_SECS);
  localparam logic [TIMER_W-1:0] PLAY_LOAD = TIMER_W'(PLAY_SECS);
  localparam logic [TIMER_W-1:0] OVER_LOAD = TIMER_W'(OVER_SECS);

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == '1) ? v : v + {{(SCORE_W-1){1'b0}}, 1'b1};
  endfunction

  phase_e             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] high_q, high_d;
  logic               new_high_q, new_high_d;
  logic               level_q, level_d;
  logic [SCORE_W-1:0] score_inc;
  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_load_val;
  logic               tmr_dec;
  logic [TIMER_W-1:0] tmr_count;
  logic               tmr_expire;

  // The timer idles at zero in IDLE, so gating the decrement there only
  // keeps stray ticks from touching it.
  assign tmr_dec   = tick_1hz && (state_q != PH_IDLE);
  assign score_inc = hit ? sat_inc(score_q) : score_q;

  phase_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec_en   (tmr_dec),
    .count    (tmr_count),
    .expire   (tmr_expire)
  );

  always_comb begin
    state_d      = state_q;
    score_d      = score_q;
    high_d       = high_q;
    new_high_d   = new_high_q;
    level_d      = level_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    case (state_q)
      PH_IDLE: begin
        if (start) begin
          state_d      = PH_COUNTDOWN;
          tmr_load     = 1'b1;
          tmr_load_val = CD_LOAD;
          score_d      = '0;
          new_high_d   = 1'b0;
          level_d      = level_select;
        end
      end
      PH_COUNTDOWN: begin
        if (tmr_expire) begin
          state_d      = PH_PLAY;
          tmr_load     = 1'b1;
          tmr_load_val = PLAY_LOAD;
        end
      end
      PH_PLAY: begin
        score_d = score_inc;
        // A hit landing with the final tick still counts toward the high score.
        if (tmr_expire) begin
          state_d      = PH_OVER;
          tmr_load     = 1'b1;
          tmr_load_val = OVER_LOAD;
          if (score_inc > high_q) begin
            high_d     = score_inc;
            new_high_d = 1'b1;
          end
        end
      end
      PH_OVER: begin
        if (start) begin
          state_d      = PH_COUNTDOWN;
          tmr_load     = 1'b1;
          tmr_load_val = CD_LOAD;
          score_d      = '0;
          new_high_d   = 1'b0;
          level_d      = level_select;
        end else if (tmr_expire) begin
          state_d      = PH_IDLE;
          tmr_load     = 1'b1;
          tmr_load_val = '0;
        end
      end
      default: state_d = PH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= PH_IDLE;
      score_q    <= '0;
      high_q     <= '0;
      new_high_q <= 1'b0;
      level_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      high_q     <= high_d;
      new_high_q <= new_high_d;
      level_q    <= level_d;
    end
  end

  assign phase         = state_q;
  assign seconds_left  = tmr_count;
  assign score         = score_q;
  assign high_score    = high_q;
  assign new_high      = new_high_q;
  assign level_latched = level_q;
  assign mole_step     = (state_q == PH_PLAY) && (level_q ? tick_2hz : tick_1hz);

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: full rounds, high-score rules, level latching,
// start-on-expiry priority, score saturation and asynchronous reset.
module tb_game_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick_1hz, tick_2hz, start, hit, level_select;
  logic [1:0]  phase;
  logic [5:0]  seconds_left;
  logic [15:0] score, high_score;
  logic        new_high, mole_step, level_latched;

  int checks  = 0;
  int errors  = 0;
  int mole_cnt = 0;

  always #5 clk = ~clk;

  game_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .tick_1hz      (tick_1hz),
    .tick_2hz      (tick_2hz),
    .start         (start),
    .hit           (hit),
    .level_select  (level_select),
    .phase         (phase),
    .seconds_left  (seconds_left),
    .score         (score),
    .high_score    (high_score),
    .new_high      (new_high),
    .mole_step     (mole_step),
    .level_latched (level_latched)
  );

  // One clock with the given pulses; counts mole_step while the pulses are applied.
  task automatic cyc(input logic t1, input logic t2, input logic st, input logic h);
    tick_1hz = t1; tick_2hz = t2; start = st; hit = h;
    #1;
    if (mole_step === 1'b1) mole_cnt++;
    @(posedge clk);
    #1;
    tick_1hz = 1'b0; tick_2hz = 1'b0; start = 1'b0; hit = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; tick_1hz = 1'b0; tick_2hz = 1'b0; hit = 1'b0; level_select = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (phase !== 2'b11) begin errors++; $display("FAIL reset_phase: got %b want 11", phase); end
    checks++; if (seconds_left !== 6'd0) begin errors++; $display("FAIL reset_secs: got %0d want 0", seconds_left); end
    checks++; if (score !== 16'd0 || high_score !== 16'd0) begin errors++; $display("FAIL reset_score: got %0d/%0d want 0/0", score, high_score); end
    checks++; if ({new_high, mole_step, level_latched} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {new_high, mole_step, level_latched}); end
    start = 1'b0; level_select = 1'b0; reset = 1'b1;
    mole_cnt = 0;
    cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 1);
    cyc(0, 0, 0, 1);
    checks++; if (phase !== 2'b11 || seconds_left !== 6'd0 || score !== 16'd0) begin errors++; $display("FAIL idle_ignore: got phase %b secs %0d score %0d want 11/0/0", phase, seconds_left, score); end
    checks++; if (mole_cnt != 0) begin errors++; $display("FAIL idle_mole: got %0d want 0", mole_cnt); end
  endtask

  task automatic test_countdown();
    cyc(0, 0, 1, 0);
    checks++; if (phase !== 2'b00 || seconds_left !== 6'd5) begin errors++; $display("FAIL cd_enter: got %b/%0d want 00/5", phase, seconds_left); end
    for (int k = 1; k <= 4; k++) begin
      cyc(0, 0, (k == 3), 0);
      cyc(1, 0, 0, (k == 2));
      checks++; if (phase !== 2'b00 || seconds_left !== 6'(5 - k)) begin errors++; $display("FAIL cd_tick%0d: got %b/%0d want 00/%0d", k, phase, seconds_left, 5 - k); end
    end
    checks++; if (score !== 16'd0) begin errors++; $display("FAIL cd_hit_ignored: got %0d want 0", score); end
    cyc(1, 0, 0, 0);
    checks++; if (phase !== 2'b01 || seconds_left !== 6'd30) begin errors++; $display("FAIL cd_to_play: got %b/%0d want 01/30", phase, seconds_left); end
  endtask

  task automatic run_countdown();
    for (int k = 0; k < 5; k++) cyc(1, 0, 0, 0);
    checks++; if (phase !== 2'b01 || seconds_left !== 6'd30) begin errors++; $display("FAIL countdown_done: got %b/%0d want 01/30", phase, seconds_left); end
  endtask

  // nhits hits: nhits-1 on idle cycles early in the round, the last with the final tick.
  task automatic play_round(input int nhits, input logic [15:0] exp_high, input logic exp_new);
    for (int s = 1; s <= 30; s++) begin
      if (s < nhits) cyc(0, 0, (s == 4), 1);
      cyc(1, 0, 0, (s == 30) && (nhits > 0));
      if (s == 15) begin
        checks++; if (seconds_left !== 6'd15 || phase !== 2'b01) begin errors++; $display("FAIL play_mid: got %b/%0d want 01/15", phase, seconds_left); end
      end
    end
    checks++; if (phase !== 2'b10 || seconds_left !== 6'd10) begin errors++; $display("FAIL round_end: got %b/%0d want 10/10", phase, seconds_left); end
    checks++; if (score !== 16'(nhits)) begin errors++; $display("FAIL round_score: got %0d want %0d", score, nhits); end
    checks++; if (high_score !== exp_high || new_high !== exp_new) begin errors++; $display("FAIL round_high: got %0d/%b want %0d/%b", high_score, new_high, exp_high, exp_new); end
  endtask

  task automatic test_first_round();
    play_round(7, 16'd7, 1'b1);
    cyc(0, 0, 0, 1);
    checks++; if (score !== 16'd7) begin errors++; $display("FAIL over_hit_ignored: got %0d want 7", score); end
    for (int k = 0; k < 9; k++) cyc(1, 0, 0, 0);
    checks++; if (phase !== 2'b10 || seconds_left !== 6'd1) begin errors++; $display("FAIL over_count: got %b/%0d want 10/1", phase, seconds_left); end
    cyc(1, 0, 0, 0);
    checks++; if (phase !== 2'b11 || seconds_left !== 6'd0 || high_score !== 16'd7) begin errors++; $display("FAIL over_to_idle: got %b/%0d/%0d want 11/0/7", phase, seconds_left, high_score); end
  endtask

  task automatic test_high_score_rules();
    cyc(0, 0, 1, 0);
    run_countdown();
    play_round(7, 16'd7, 1'b0);
    cyc(0, 0, 1, 0);
    checks++; if (phase !== 2'b00 || score !== 16'd0 || new_high !== 1'b0) begin errors++; $display("FAIL restart_from_over: got %b/%0d/%b want 00/0/0", phase, score, new_high); end
    run_countdown();
    play_round(9, 16'd9, 1'b1);
  endtask

  task automatic test_level_latch();
    level_select = 1'b1;
    cyc(0, 0, 1, 0);
    checks++; if (level_latched !== 1'b1) begin errors++; $display("FAIL level_latch: got %b want 1", level_latched); end
    mole_cnt = 0;
    for (int k = 0; k < 5; k++) cyc(1, 1, 0, 0);
    checks++; if (mole_cnt != 0 || phase !== 2'b01) begin errors++; $display("FAIL cd_mole: got %0d moles phase %b want 0/01", mole_cnt, phase); end
    for (int s = 1; s <= 30; s++) begin
      if (s == 10) level_select = 1'b0;
      cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(1, 1, 0, 0);
    end
    checks++; if (mole_cnt != 60) begin errors++; $display("FAIL play_mole: got %0d want 60", mole_cnt); end
    checks++; if (phase !== 2'b10 || seconds_left !== 6'd10 || level_latched !== 1'b1) begin errors++; $display("FAIL fast_round_end: got %b/%0d/%b want 10/10/1", phase, seconds_left, level_latched); end
    checks++; if (high_score !== 16'd9 || new_high !== 1'b0 || score !== 16'd0) begin errors++; $display("FAIL fast_round_score: got %0d/%b/%0d want 9/0/0", high_score, new_high, score); end
    mole_cnt = 0;
    for (int k = 0; k < 3; k++) cyc(1, 1, 0, 0);
    checks++; if (mole_cnt != 0) begin errors++; $display("FAIL over_mole: got %0d want 0", mole_cnt); end
  endtask

  task automatic test_start_on_expiry();
    for (int k = 0; k < 6; k++) cyc(1, 0, 0, 0);
    checks++; if (phase !== 2'b10 || seconds_left !== 6'd1) begin errors++; $display("FAIL pre_expiry: got %b/%0d want 10/1", phase, seconds_left); end
    cyc(1, 0, 1, 0);
    checks++; if (phase !== 2'b00 || seconds_left !== 6'd5) begin errors++; $display("FAIL start_on_expiry: got %b/%0d want 00/5", phase, seconds_left); end
    checks++; if (score !== 16'd0 || high_score !== 16'd9 || level_latched !== 1'b0) begin errors++; $display("FAIL expiry_init: got %0d/%0d/%b want 0/9/0", score, high_score, level_latched); end
  endtask

  task automatic test_saturation();
    run_countdown();
    cyc(0, 0, 0, 1);
    checks++; if (score !== 16'd1) begin errors++; $display("FAIL play_hit: got %0d want 1", score); end
    force dut.score_q = 16'hFFFF;
    hit = 1'b1;
    #1;
    checks++; if (dut.score_d !== 16'hFFFF) begin errors++; $display("FAIL sat_next: got %h want ffff", dut.score_d); end
    @(posedge clk);
    #1;
    hit = 1'b0;
    checks++; if (score !== 16'hFFFF) begin errors++; $display("FAIL sat_score: got %h want ffff", score); end
    release dut.score_q;
  endtask

  task automatic test_async_reset();
    cyc(1, 0, 0, 0);
    checks++; if (phase !== 2'b01) begin errors++; $display("FAIL pre_reset_play: got %b want 01", phase); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (phase !== 2'b11 || seconds_left !== 6'd0) begin errors++; $display("FAIL async_reset: got %b/%0d want 11/0", phase, seconds_left); end
    checks++; if (high_score !== 16'd0 || score !== 16'd0 || new_high !== 1'b0) begin errors++; $display("FAIL async_reset_score: got %0d/%0d/%b want 0/0/0", high_score, score, new_high); end
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (phase !== 2'b11) begin errors++; $display("FAIL post_reset_idle: got %b want 11", phase); end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_first_round();
    test_high_score_rules();
    test_level_latch();
    test_start_on_expiry();
    test_saturation();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
